// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver
// Scans a HUB75 LED panel chain with binary code modulation (BCM). For each
// scan row and each colour bit plane the driver shifts one row of pixels
// into the panel, latches it, lights it for a time proportional to the
// plane weight, then blanks before moving on.
//
// Ports
//   clk, reset         system clock, asynchronous active-high reset
//   enable             scan run; low returns the driver to idle
//   pix_addr, pix_rd   framebuffer read address {row, col} and read strobe
//   pix_data           read data, one cycle after pix_rd; per chain
//                      {b1,g1,r1,b0,g0,r0}, each DEPTH bits
//   led_r0..led_b1     colour data, one bit per chain
//   led_clk, led_lat   shift clock and latch strobe
//   led_oe             output enable, active-low
//   led_row            scan row select
//   frame_start        one-cycle pulse on the first shift of every frame
//
// Optional feature (macro HUB75_FRAME_SWAP_EN): double-buffered framebuffer.
// Adds swap_req/swap_ack/buf_sel; buf_sel becomes the pix_addr MSB and only
// toggles at a frame boundary so a frame is never drawn from two buffers.
// BLANK_CYC and OE_BASE are expected to be at least 1.
module hub75_bcm_driver #(
  parameter int COLS      = 64,
  parameter int ROW_BITS  = 4,
  parameter int DEPTH     = 8,
  parameter int CHAINS    = 1,
  parameter int CLK_DIV   = 2,
  parameter int OE_BASE   = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
`ifdef HUB75_FRAME_SWAP_EN
  input  logic                                swap_req,
  output logic                                swap_ack,
  output logic                                buf_sel,
  output logic [ROW_BITS+$clog2(COLS):0]      pix_addr,
`else
  output logic [ROW_BITS+$clog2(COLS)-1:0]    pix_addr,
`endif
  output logic                                pix_rd,
  input  logic [6*DEPTH*CHAINS-1:0]           pix_data,
  output logic [CHAINS-1:0]                   led_r0,
  output logic [CHAINS-1:0]                   led_g0,
  output logic [CHAINS-1:0]                   led_b0,
  output logic [CHAINS-1:0]                   led_r1,
  output logic [CHAINS-1:0]                   led_g1,
  output logic [CHAINS-1:0]                   led_b1,
  output logic                                led_clk,
  output logic                                led_lat,
  output logic                                led_oe,
  output logic [ROW_BITS-1:0]                 led_row,
  output logic                                frame_start
);

  localparam int COL_BITS = $clog2(COLS);
  localparam int ADDR_W   = ROW_BITS + COL_BITS;
  localparam int PH_W     = $clog2(2 * CLK_DIV);
  localparam int PLANE_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_OE   = OE_BASE << (DEPTH - 1);
  localparam int CNT_W    = $clog2(((MAX_OE > BLANK_CYC) ? MAX_OE : BLANK_CYC) + 2) + 1;

  typedef enum logic [2:0] {IDLE, SHIFT, LATCH, DISPLAY, BLANK} state_t;

  state_t              state;
  logic [ROW_BITS-1:0] row;
  logic [PLANE_W-1:0]  plane;
  logic [COL_BITS-1:0] col;
  logic [PH_W-1:0]     phase;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;

  logic [PH_W-1:0]     phase_nxt;
  logic [CNT_W-1:0]    disp_last;
  logic [CNT_W-1:0]    blank_last;
  logic                last_phase;
  logic                last_col;
  logic                last_row;
  logic                last_plane;
  logic [CHAINS-1:0]   bit_sel [6];

  assign phase_nxt  = phase + PH_W'(1);
  // Display time doubles with each bit plane, giving the BCM weighting.
  assign disp_last  = (CNT_W'(OE_BASE) << plane) - CNT_W'(1);
  assign blank_last = CNT_W'(BLANK_CYC - 1);
  assign last_phase = (phase == PH_W'(2 * CLK_DIV - 1));
  assign last_col   = &col;
  assign last_row   = &row;
  assign last_plane = (plane == PLANE_W'(DEPTH - 1));

  // Pick the current plane bit out of every colour channel of every chain;
  // index k follows the pix_data channel order r0,g0,b0,r1,g1,b1.
  always_comb begin
    logic [DEPTH-1:0] chan;
    for (int k = 0; k < 6; k++) begin
      bit_sel[k] = '0;
      for (int c = 0; c < CHAINS; c++) begin
        chan           = pix_data[(c * 6 + k) * DEPTH +: DEPTH];
        bit_sel[k][c]  = chan[plane];
      end
    end
  end

  // Scan sequencer. All panel-facing outputs are registered and are loaded
  // with the value they must show in the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      row         <= '0;
      plane       <= '0;
      col         <= '0;
      phase       <= '0;
      cnt         <= '0;
      addr_q      <= '0;
      pix_rd      <= 1'b0;
      led_r0      <= '0;
      led_g0      <= '0;
      led_b0      <= '0;
      led_r1      <= '0;
      led_g1      <= '0;
      led_b1      <= '0;
      led_clk     <= 1'b0;
      led_lat     <= 1'b0;
      led_oe      <= 1'b1;
      led_row     <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_rd      <= 1'b0;
      frame_start <= 1'b0;
      if (!enable) begin
        // Colour data and led_row are left alone so the panel sees no
        // spurious change; it is dark anyway with led_oe high.
        state   <= IDLE;
        row     <= '0;
        plane   <= '0;
        col     <= '0;
        phase   <= '0;
        cnt     <= '0;
        led_clk <= 1'b0;
        led_lat <= 1'b0;
        led_oe  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            state       <= SHIFT;
            row         <= '0;
            plane       <= '0;
            col         <= '0;
            phase       <= '0;
            cnt         <= '0;
            addr_q      <= '0;
            pix_rd      <= 1'b1;
            frame_start <= 1'b1;
            led_row     <= '0;
            led_oe      <= 1'b1;
            led_clk     <= 1'b0;
            led_lat     <= 1'b0;
          end
          SHIFT: begin
            // Read data arrives in phase 1 and is presented from phase 2 on.
            if (phase == PH_W'(1)) begin
              led_r0 <= bit_sel[0];
              led_g0 <= bit_sel[1];
              led_b0 <= bit_sel[2];
              led_r1 <= bit_sel[3];
              led_g1 <= bit_sel[4];
              led_b1 <= bit_sel[5];
            end
            if (last_phase) begin
              led_clk <= 1'b0;
              phase   <= '0;
              if (last_col) begin
                state   <= LATCH;
                led_lat <= 1'b1;
                led_row <= row;
                cnt     <= '0;
              end else begin
                col    <= col + COL_BITS'(1);
                addr_q <= {row, col + COL_BITS'(1)};
                pix_rd <= 1'b1;
              end
            end else begin
              phase   <= phase_nxt;
              led_clk <= (phase_nxt >= PH_W'(CLK_DIV));
            end
          end
          LATCH: begin
            if (cnt == CNT_W'(1)) begin
              state   <= DISPLAY;
              led_lat <= 1'b0;
              led_oe  <= 1'b0;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          DISPLAY: begin
            if (cnt == disp_last) begin
              state  <= BLANK;
              led_oe <= 1'b1;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          BLANK: begin
            if (cnt == blank_last) begin
              state  <= SHIFT;
              cnt    <= '0;
              col    <= '0;
              phase  <= '0;
              pix_rd <= 1'b1;
              if (last_plane) begin
                plane       <= '0;
                row         <= row + ROW_BITS'(1);
                addr_q      <= {row + ROW_BITS'(1), COL_BITS'(0)};
                frame_start <= last_row;
              end else begin
                plane  <= plane + PLANE_W'(1);
                addr_q <= {row, COL_BITS'(0)};
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef HUB75_FRAME_SWAP_EN
  logic wrap_now;

  // True on the edge that leaves the final blank of the final row.
  assign wrap_now = enable && (state == BLANK) && (cnt == blank_last) && last_plane && last_row;

  // Buffer flip happens only on the frame wrap edge, so the first read of
  // the new frame already addresses the new buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_sel  <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      swap_ack <= wrap_now && swap_req;
      if (wrap_now && swap_req) begin
        buf_sel <= ~buf_sel;
      end
    end
  end

  assign pix_addr = {buf_sel, addr_q};
`else
  assign pix_addr = addr_q;
`endif

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Testbench for hub75_bcm_driver with a small panel configuration.
// A framebuffer model answers reads; expected panel waveforms come from a
// timing model that derives row/plane/column purely from the cycle index.
// Supports the HUB75_FRAME_SWAP_EN build as well as the default build.
module tb_hub75_bcm_driver;

  localparam int COLS      = 4;
  localparam int ROW_BITS  = 1;
  localparam int DEPTH     = 2;
  localparam int CHAINS    = 1;
  localparam int CLK_DIV   = 2;
  localparam int OE_BASE   = 8;
  localparam int BLANK_CYC = 2;

  localparam int COL_BITS = $clog2(COLS);
  localparam int ADDR_W   = ROW_BITS + COL_BITS;
  localparam int PW       = 6 * DEPTH * CHAINS;
  localparam int MEM_N    = 2 ** (ADDR_W + 1);
  localparam int ROWS     = 2 ** ROW_BITS;
  localparam int SH       = COLS * 2 * CLK_DIV;
  // Sum over planes of shift + latch + blank, plus the geometric series of
  // display times OE_BASE * (1 + 2 + ... + 2**(DEPTH-1)).
  localparam int ROW_LEN  = DEPTH * (SH + 2 + BLANK_CYC) + OE_BASE * ((1 << DEPTH) - 1);
  localparam int FRAME    = ROWS * ROW_LEN;

  typedef struct {
    logic oe, lat, clk, rd, fs, dvalid, display, shift;
    int   row, plane, col, led_row;
  } exp_t;

  logic                clk;
  logic                reset;
  logic                enable;
  logic                pix_rd;
  logic [PW-1:0]       pix_data;
  logic [CHAINS-1:0]   led_r0, led_g0, led_b0, led_r1, led_g1, led_b1;
  logic                led_clk, led_lat, led_oe, frame_start;
  logic [ROW_BITS-1:0] led_row;
  logic [ADDR_W:0]     full_addr;
  logic [5:0]          obs_led;

  logic [PW-1:0] mem [MEM_N];
  int            checks;
  int            errors;
  int            tcyc;
  logic          exp_buf;
  logic          exp_ack;
  logic [5:0]    last_led;
  logic          swap_test;
  exp_t          e;

`ifdef HUB75_FRAME_SWAP_EN
  logic              swap_req;
  logic              swap_ack;
  logic              buf_sel;
  logic [ADDR_W:0]   pix_addr;

  assign full_addr = pix_addr;
`else
  logic [ADDR_W-1:0] pix_addr;

  assign full_addr = {1'b0, pix_addr};
`endif

  assign obs_led = {led_b1[0], led_g1[0], led_r1[0], led_b0[0], led_g0[0], led_r0[0]};

  hub75_bcm_driver #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .DEPTH(DEPTH), .CHAINS(CHAINS),
    .CLK_DIV(CLK_DIV), .OE_BASE(OE_BASE), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
`ifdef HUB75_FRAME_SWAP_EN
    .swap_req(swap_req),
    .swap_ack(swap_ack),
    .buf_sel(buf_sel),
`endif
    .pix_addr(pix_addr),
    .pix_rd(pix_rd),
    .pix_data(pix_data),
    .led_r0(led_r0),
    .led_g0(led_g0),
    .led_b0(led_b0),
    .led_r1(led_r1),
    .led_g1(led_g1),
    .led_b1(led_b1),
    .led_clk(led_clk),
    .led_lat(led_lat),
    .led_oe(led_oe),
    .led_row(led_row),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer: a read strobe seen mid-cycle makes data valid for the next cycle.
  always @(negedge clk) begin
    if (pix_rd === 1'b1) pix_data = mem[full_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0d: got %0h, expected %0h", tag, tcyc, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en);
    reset  = rst;
    enable = en;
  endtask

  function automatic logic [5:0] ledBits(input logic [PW-1:0] w, input int p);
    logic [PW-1:0] tmp;
    ledBits = '0;
    for (int k = 0; k < 6; k++) begin
      tmp        = w >> (k * DEPTH + p);
      ledBits[k] = tmp[0];
    end
  endfunction

  // Expected panel behaviour for cycle t, counted from the first shift cycle.
  function automatic exp_t modelAt(input int t);
    exp_t r;
    int   ft, o, ph, plen;
    ft      = t % FRAME;
    r.row   = ft / ROW_LEN;
    o       = ft % ROW_LEN;
    r.plane = 0;
    plen    = SH + 2 + OE_BASE + BLANK_CYC;
    while (o >= plen) begin
      o       = o - plen;
      r.plane = r.plane + 1;
      plen    = SH + 2 + (OE_BASE << r.plane) + BLANK_CYC;
    end
    r.fs = (ft == 0);
    r.oe = 1'b1; r.lat = 1'b0; r.clk = 1'b0; r.rd = 1'b0;
    r.dvalid = 1'b1; r.display = 1'b0; r.shift = 1'b0;
    r.col = COLS - 1;
    if (o < SH) begin
      r.col    = o / (2 * CLK_DIV);
      ph       = o % (2 * CLK_DIV);
      r.rd     = (ph == 0);
      r.clk    = (ph >= CLK_DIV);
      r.dvalid = (ph >= 2);
      r.shift  = 1'b1;
    end else if (o < SH + 2) begin
      r.lat = 1'b1;
    end else if (o < SH + 2 + (OE_BASE << r.plane)) begin
      r.oe      = 1'b0;
      r.display = 1'b1;
    end
    // The row select moves to the new row at the first latch of that row.
    if (r.plane == 0 && o < SH)
      r.led_row = (t < FRAME && r.row == 0) ? 0 : (r.row + ROWS - 1) % ROWS;
    else
      r.led_row = r.row;
    return r;
  endfunction

  task automatic checkCycle();
    exp_t            m;
    logic [ADDR_W:0] idx;
    logic [5:0]      d;
    exp_ack = 1'b0;
`ifdef HUB75_FRAME_SWAP_EN
    if (tcyc > 0 && (tcyc % FRAME) == 0 && swap_req) begin
      exp_buf = ~exp_buf;
      exp_ack = 1'b1;
    end
`endif
    m   = modelAt(tcyc);
    idx = {exp_buf, ROW_BITS'(m.row), COL_BITS'(m.col)};
    checkOutput("led_oe", 32'(led_oe), 32'(m.oe));
    checkOutput("led_lat", 32'(led_lat), 32'(m.lat));
    checkOutput("led_clk", 32'(led_clk), 32'(m.clk));
    checkOutput("pix_rd", 32'(pix_rd), 32'(m.rd));
    checkOutput("frame_start", 32'(frame_start), 32'(m.fs));
    checkOutput("led_row", 32'(led_row), m.led_row);
    if (m.rd) checkOutput("pix_addr", 32'(full_addr), 32'(idx));
    if (m.dvalid) begin
      d        = ledBits(mem[idx], m.plane);
      last_led = d;
      checkOutput("led_data", 32'(obs_led), 32'(d));
    end
`ifdef HUB75_FRAME_SWAP_EN
    checkOutput("swap_ack", 32'(swap_ack), 32'(exp_ack));
    checkOutput("buf_sel", 32'(buf_sel), 32'(exp_buf));
`endif
    tcyc++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkCycle();
`ifdef HUB75_FRAME_SWAP_EN
      if (swap_test && tcyc == 40) swap_req = 1'b1;
      if (tcyc == FRAME + 1) swap_req = 1'b0;
`endif
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_led_data"}, 32'(obs_led), 32'd0);
    checkOutput({tag, "_led_clk"}, 32'(led_clk), 32'd0);
    checkOutput({tag, "_led_lat"}, 32'(led_lat), 32'd0);
    checkOutput({tag, "_led_row"}, 32'(led_row), 32'd0);
    checkOutput({tag, "_pix_addr"}, 32'(full_addr), 32'd0);
    checkOutput({tag, "_pix_rd"}, 32'(pix_rd), 32'd0);
    checkOutput({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    checkOutput({tag, "_led_oe"}, 32'(led_oe), 32'd1);
`ifdef HUB75_FRAME_SWAP_EN
    checkOutput({tag, "_buf_sel"}, 32'(buf_sel), 32'd0);
    checkOutput({tag, "_swap_ack"}, 32'(swap_ack), 32'd0);
`endif
  endtask

  // Buffer 0 gets bit 0 of every channel set and bit 1 clear; buffer 1 random.
  task automatic fillPattern();
    logic [PW-1:0] w;
    w = '0;
    for (int k = 0; k < 6 * CHAINS; k++) w = w | (PW'(1) << (k * DEPTH));
    for (int i = 0; i < MEM_N; i++) mem[i] = (i < MEM_N / 2) ? w : PW'($urandom);
  endtask

  task automatic fillRandom();
    for (int i = 0; i < MEM_N; i++) mem[i] = PW'($urandom);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    tcyc      = 0;
    exp_buf   = 1'b0;
    exp_ack   = 1'b0;
    last_led  = '0;
    swap_test = 1'b0;
    pix_data  = '0;
`ifdef HUB75_FRAME_SWAP_EN
    swap_req  = 1'b0;
`endif
    applyStimulus(1'b1, 1'b0);
    fillPattern();
    repeat (3) @(negedge clk);
    checkResetValues("por");

    applyStimulus(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("idle_oe", 32'(led_oe), 32'd1);
    checkOutput("idle_rd", 32'(pix_rd), 32'd0);
    checkOutput("idle_fs", 32'(frame_start), 32'd0);
    checkOutput("idle_clk", 32'(led_clk), 32'd0);

    $display("[TB] run 1: plane pattern, frame timing, buffer swap");
    applyStimulus(1'b0, 1'b1);
    tcyc      = 0;
    swap_test = 1'b1;
    runCycles(2 * FRAME + 10);
    swap_test = 1'b0;

    $display("[TB] enable dropped during display");
    runCycles(int'($urandom_range(0, 60)));
    e = modelAt(tcyc - 1);
    while (!e.display) begin
      runCycles(1);
      e = modelAt(tcyc - 1);
    end
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("dis_oe", 32'(led_oe), 32'd1);
    checkOutput("dis_rd", 32'(pix_rd), 32'd0);
    checkOutput("dis_clk", 32'(led_clk), 32'd0);
    checkOutput("dis_lat", 32'(led_lat), 32'd0);
    checkOutput("dis_led_hold", 32'(obs_led), 32'(last_led));
    repeat (int'($urandom_range(2, 10))) @(negedge clk);
    checkOutput("dis_idle_oe", 32'(led_oe), 32'd1);
    checkOutput("dis_idle_led_hold", 32'(obs_led), 32'(last_led));
    fillRandom();
    applyStimulus(1'b0, 1'b1);
    tcyc = 0;
    runCycles(FRAME + 20);

    $display("[TB] asynchronous reset during shift");
    runCycles(int'($urandom_range(0, 40)));
    e = modelAt(tcyc - 1);
    while (!e.shift) begin
      runCycles(1);
      e = modelAt(tcyc - 1);
    end
    #1 applyStimulus(1'b1, 1'b1);
    #1 checkResetValues("async_rst");
    exp_buf = 1'b0;
    fillRandom();
    @(negedge clk);
    checkResetValues("rst_hold");
    applyStimulus(1'b0, 1'b1);
    tcyc = 0;
    runCycles(FRAME + 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hub75_bcm_driver.md
HUB75_BCM_DRIVER -- requirements
Module: hub75_bcm_driver

Interface
REQ-001 SHALL have parameter: COLS, 64, pixels per chain row (power of 2, >=2).
REQ-002 SHALL have parameter: ROW_BITS, 4, scan row address width (2**ROW_BITS scan rows).
REQ-003 SHALL have parameter: DEPTH, 8, colour bits per channel (BCM bit planes).
REQ-004 SHALL have parameter: CHAINS, 1, parallel panel chains (1..4).
REQ-005 SHALL have parameter: CLK_DIV, 2, clk cycles per led_clk half-period (>=2).
REQ-006 SHALL have parameter: OE_BASE, 8, display cycles of bit plane 0.
REQ-007 SHALL have parameter: BLANK_CYC, 2, oe-high cycles after each display.
REQ-008 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-009 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-010 SHALL have port: enable  input  1  scan run; low forces idle.
REQ-011 SHALL have port: pix_addr  output  ROW_BITS+log2(COLS)  {row, col} framebuffer read address.
REQ-012 SHALL have port: pix_rd  output  1  one-cycle read strobe.
REQ-013 SHALL have port: pix_data  input  6*DEPTH*CHAINS  read data; valid the cycle after pix_rd; chain c slice [c*6*DEPTH +: 6*DEPTH] = {b1,g1,r1,b0,g0,r0}, each DEPTH bits.
REQ-014 SHALL have port: led_r0  output  CHAINS  upper-half red, one bit per chain.
REQ-015 SHALL have port: led_g0  output  CHAINS  upper-half green.
REQ-016 SHALL have port: led_b0  output  CHAINS  upper-half blue.
REQ-017 SHALL have port: led_r1  output  CHAINS  lower-half red.
REQ-018 SHALL have port: led_g1  output  CHAINS  lower-half green.
REQ-019 SHALL have port: led_b1  output  CHAINS  lower-half blue.
REQ-020 SHALL have port: led_clk  output  1  shift clock, shared by all chains.
REQ-021 SHALL have port: led_lat  output  1  latch strobe.
REQ-022 SHALL have port: led_oe  output  1  output enable, active-low.
REQ-023 SHALL have port: led_row  output  ROW_BITS  scan row select.
REQ-024 SHALL have port: frame_start  output  1  one-cycle pulse at frame begin.

Function
REQ-025 SHALL run states IDLE -> SHIFT -> LATCH -> DISPLAY -> BLANK -> SHIFT (next plane).
REQ-026 IDLE SHALL exit to SHIFT (row 0, plane 0) the cycle after enable is sampled high; frame_start SHALL pulse in that first SHIFT cycle.
REQ-027 SHIFT SHALL take 2*CLK_DIV cycles per column, columns 0..COLS-1: pix_rd high in phase cycle 0, led_* data = bit [plane] of pix_data registered in phase cycle 1, led_clk high for phase cycles CLK_DIV..2*CLK_DIV-1.
REQ-028 LATCH SHALL last 2 cycles, led_clk low, led_lat high, led_oe high, led_row updated to current row in first LATCH cycle.
REQ-029 DISPLAY SHALL hold led_oe low for exactly OE_BASE<<plane cycles; BLANK SHALL hold led_oe high for BLANK_CYC cycles.
REQ-030 After BLANK of plane DEPTH-1 the row SHALL increment, plane reset to 0; row 2**ROW_BITS-1 SHALL wrap to 0 and pulse frame_start.
REQ-031 led_oe SHALL be high in every state except DISPLAY; led_row SHALL change only while led_oe is high.
REQ-032 enable low in any state SHALL, next cycle, enter IDLE: led_oe high, led_clk/led_lat/pix_rd low, row and plane cleared; led data held.

Reset
REQ-033 Reset SHALL force IDLE; led_r*/g*/b*, led_clk, led_lat, led_row, pix_addr, pix_rd, frame_start = 0; led_oe = 1.
REQ-034 Reset asserted mid-operation SHALL take effect immediately (asynchronously) with the values of REQ-033.

Configuration
REQ-035 Macro HUB75_FRAME_SWAP_EN defined SHALL add ports swap_req (in, 1), swap_ack (out, 1), buf_sel (out, 1, reset 0) and prepend buf_sel as pix_addr MSB.
REQ-036 With the macro, a held swap_req SHALL toggle buf_sel and pulse swap_ack for one cycle at frame wrap (REQ-030), never mid-frame.
REQ-037 Without the macro those ports SHALL be absent and pix_addr SHALL be ROW_BITS+log2(COLS) wide.

Verification (COLS=4, ROW_BITS=1, DEPTH=2, CHAINS=1, CLK_DIV=2, OE_BASE=8, BLANK_CYC=2)
REQ-038 enable high from reset -> plane 0 = 16 shift + 2 latch + 8 oe-low + 2 blank = 28 cycles, plane 1 = 36; frame_start period 128 cycles.
REQ-039 pix_data all-ones in plane 0 bit, zeros in bit 1 -> led_r0..led_b1 = 1 at 4 led_clk rises of plane 0, 0 in plane 1.
REQ-040 enable dropped during DISPLAY -> next cycle led_oe = 1, pix_rd = 0; re-enable -> frame_start, led_row = 0.
REQ-041 reset pulse mid-SHIFT -> outputs equal REQ-033 values same cycle; restart as REQ-038.
REQ-042 HUB75_FRAME_SWAP_EN, swap_req raised at cycle 40 -> swap_ack pulse and buf_sel = 1 at first frame wrap, pix_addr MSB = 1 thereafter.
